// File: rtl/cv32e40p_wfi_sleep_ctrl.sv
// WFI sleep sequencer for the non-cluster core configuration.
// On a WFI it drains fetch, LSU and APU activity, then closes the core clock gate.
// A wake event reopens the gate, which stays open for a settle window before the
// controller is released. It also keeps a saturating count of gated cycles.
module cv32e40p_wfi_sleep_ctrl #(
  parameter int unsigned WAKE_DELAY = 2,   // settle cycles after wake, 1..255
  parameter int unsigned CNT_W      = 32   // sleep-cycle counter width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wfi_req_i,
  input  logic             if_busy_i,
  input  logic             lsu_busy_i,
  input  logic             apu_busy_i,
  input  logic             irq_pending_i,
  input  logic             debug_req_i,
  input  logic             debug_mode_i,
  input  logic             sleep_cnt_clr_i,
  output logic             clock_en_o,
  output logic             core_sleep_o,
  output logic             wfi_done_o,
  output logic [CNT_W-1:0] sleep_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SLEEP,
    ST_WAKE
  } state_e;

  localparam logic [7:0]       WAKE_LOAD = 8'(WAKE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic [7:0]       r_wake_cnt;
  logic [7:0]       w_wake_cnt_nxt;
  logic             r_core_sleep;
  logic             r_wfi_done;
  logic             w_wfi_done_nxt;
  logic [CNT_W-1:0] r_sleep_cnt;
  logic             w_wake;
  logic             w_busy;

  assign w_wake = irq_pending_i | debug_req_i | debug_mode_i;
  assign w_busy = if_busy_i | lsu_busy_i | apu_busy_i;

  // Next-state and settle-counter logic for the sleep sequence.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_wake_cnt_nxt = r_wake_cnt;
    w_wfi_done_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (wfi_req_i) begin
          if (w_wake) begin
            w_wfi_done_nxt = 1'b1;       // wake already pending: WFI is a NOP
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_wake) begin                // abort takes priority over draining
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = WAKE_LOAD;
        end else if (!w_busy) begin
          w_state_nxt = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (w_wake) begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // The settle window runs to completion even if the wake source drops.
        if (r_wake_cnt == 8'd0) begin
          w_state_nxt    = ST_IDLE;
          w_wfi_done_nxt = 1'b1;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt - 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, settle counter and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_wake_cnt   <= 8'd0;
      r_core_sleep <= 1'b0;
      r_wfi_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wake_cnt   <= w_wake_cnt_nxt;
      r_core_sleep <= (w_state_nxt == ST_SLEEP);
      r_wfi_done   <= w_wfi_done_nxt;
    end
  end

  // Saturating count of cycles with the core clock actually gated; clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sleep_cnt <= '0;
    end else if (sleep_cnt_clr_i) begin
      r_sleep_cnt <= '0;
    end else if (r_state == ST_SLEEP && !w_wake && r_sleep_cnt != CNT_MAX) begin
      r_sleep_cnt <= r_sleep_cnt + CNT_W'(1);
    end
  end

  // The gate reopens combinationally in the very cycle a wake event arrives.
  assign clock_en_o   = !r_core_sleep | w_wake;
  assign core_sleep_o = r_core_sleep;
  assign wfi_done_o   = r_wfi_done;
  assign sleep_cnt_o  = r_sleep_cnt;

endmodule

// File: tb/tb_cv32e40p_wfi_sleep_ctrl.sv
// Testbench for cv32e40p_wfi_sleep_ctrl: directed scenarios plus random traffic,
// scored against an event-scheduling reference model through an expectation queue.
module tb_cv32e40p_wfi_sleep_ctrl;

  localparam int WD      = 2;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wfi_req_i, if_busy_i, lsu_busy_i, apu_busy_i;
  logic          irq_pending_i, debug_req_i, debug_mode_i, sleep_cnt_clr_i;
  logic          clock_en_o, core_sleep_o, wfi_done_o;
  logic [CW-1:0] sleep_cnt_o;

  cv32e40p_wfi_sleep_ctrl #(.WAKE_DELAY(WD), .CNT_W(CW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .wfi_req_i       (wfi_req_i),
    .if_busy_i       (if_busy_i),
    .lsu_busy_i      (lsu_busy_i),
    .apu_busy_i      (apu_busy_i),
    .irq_pending_i   (irq_pending_i),
    .debug_req_i     (debug_req_i),
    .debug_mode_i    (debug_mode_i),
    .clock_en_o      (clock_en_o),
    .core_sleep_o    (core_sleep_o),
    .wfi_done_o      (wfi_done_o),
    .sleep_cnt_clr_i (sleep_cnt_clr_i),
    .sleep_cnt_o     (sleep_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int      cyc;
    logic    ce;
    logic    sl;
    logic    dn;
    int      cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  // Reference model: cycle timestamps rather than a state encoding.
  bit m_drain;        // waiting for busy to clear
  bit m_gated;        // clock gate closed (asleep)
  int m_idle_from;    // first cycle at which a new WFI is accepted
  int m_done_cyc;     // cycle in which wfi_done_o must be high
  int m_cnt;

  task automatic model_reset();
    m_drain     = 1'b0;
    m_gated     = 1'b0;
    m_idle_from = 0;
    m_done_cyc  = -1;
    m_cnt       = 0;
  endtask

  task automatic check(input string name, input int c, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, c, act, exp);
    end
  endtask

  task automatic zero_inputs();
    wfi_req_i = 0; if_busy_i = 0; lsu_busy_i = 0; apu_busy_i = 0;
    irq_pending_i = 0; debug_req_i = 0; debug_mode_i = 0; sleep_cnt_clr_i = 0;
  endtask

  // One clock cycle of stimulus: drive, predict this cycle's outputs, advance the model.
  task automatic drive_cycle(input bit req, input bit ifb, input bit lsu, input bit apu,
                             input bit irq, input bit dbg, input bit dm, input bit clr);
    bit   wake, idle;
    exp_t e;
    @(posedge clk_i);
    #1;
    wfi_req_i = req; if_busy_i = ifb; lsu_busy_i = lsu; apu_busy_i = apu;
    irq_pending_i = irq; debug_req_i = dbg; debug_mode_i = dm; sleep_cnt_clr_i = clr;
    wake  = irq | dbg | dm;
    e.cyc = cyc;
    e.ce  = !m_gated || wake;
    e.sl  = m_gated;
    e.dn  = (m_done_cyc == cyc);
    e.cnt = m_cnt;
    sb_q.push_back(e);

    if (clr) m_cnt = 0;
    else if (m_gated && !wake && m_cnt < CNT_MAX) m_cnt++;

    idle = !m_drain && !m_gated && (cyc >= m_idle_from);
    if (idle) begin
      if (req) begin
        if (wake) m_done_cyc = cyc + 1;
        else      m_drain    = 1'b1;
      end
    end else if (m_drain) begin
      if (wake) begin
        m_drain     = 1'b0;
        m_idle_from = cyc + WD + 1;
        m_done_cyc  = m_idle_from;
      end else if (!(ifb | lsu | apu)) begin
        m_drain = 1'b0;
        m_gated = 1'b1;
      end
    end else if (m_gated && wake) begin
      m_gated     = 1'b0;
      m_idle_from = cyc + WD + 1;
      m_done_cyc  = m_idle_from;
    end
    cyc++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: mid-cycle, compare the DUT against the oldest pending expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("clock_en",   e.cyc, int'(clock_en_o),   int'(e.ce));
      check("core_sleep", e.cyc, int'(core_sleep_o), int'(e.sl));
      check("wfi_done",   e.cyc, int'(wfi_done_o),   int'(e.dn));
      check("sleep_cnt",  e.cyc, int'(sleep_cnt_o),  e.cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    zero_inputs();
    model_reset();
    rst_i = 1'b1;
    #23;
    check("rst_clock_en",   -1, int'(clock_en_o),   1);
    check("rst_core_sleep", -1, int'(core_sleep_o), 0);
    check("rst_wfi_done",   -1, int'(wfi_done_o),   0);
    check("rst_sleep_cnt",  -1, int'(sleep_cnt_o),  0);
    rst_i = 1'b0;

    // Fastest entry, irq wake 10 cycles after the request.
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 10; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    quiet(5);
    @(negedge clk_i);
    check("tp_sleep_cnt_8", cyc, int'(sleep_cnt_o), 8);

    // Drain held off by LSU busy for six cycles.
    drive_cycle(1, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 1; i < 6; i++) drive_cycle(0, 0, 1, 0, 0, 0, 0, 0);
    quiet(6);
    drive_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    quiet(5);

    // NOP WFI while in debug mode.
    drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
    quiet(4);

    // Abort during drain with APU busy held.
    drive_cycle(1, 0, 0, 1, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, 1, 0, 0, 0, 0);

    // Long sleep: saturation, then a clear mid-sleep and resumed counting.
    drive_cycle(1, 1, 0, 0, 0, 0, 0, 1);
    quiet(22);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    quiet(5);
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    quiet(5);

    // Reset while asleep: immediate clock enable, no done pulse afterwards.
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    quiet(4);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("rst_sleep_clock_en",   cyc, int'(clock_en_o),   1);
    check("rst_sleep_core_sleep", cyc, int'(core_sleep_o), 0);
    zero_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("rst_hold_wfi_done", cyc, int'(wfi_done_o), 0);
    end
    #2;
    rst_i = 1'b0;
    model_reset();
    quiet(4);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    quiet(3);
    drive_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    quiet(4);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      drive_cycle($urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 47) == 0,
                  $urandom_range(0, 39) == 0);
    end

    @(negedge clk_i);
    #1;
    check("scoreboard_drained", cyc, sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
